// File: rtl/clock_time_pkg.sv
// Shared types and modulus constants for the HH:MM:SS time-of-day controller.
package clock_time_pkg;

    typedef enum logic [1:0] {
        STOP    = 2'd0,
        RUN     = 2'd1,
        SET_MIN = 2'd2,
        SET_HR  = 2'd3
    } state_t;

    localparam int unsigned SEC_MOD = 60;
    localparam int unsigned MIN_MOD = 60;
    localparam int unsigned HR_MOD  = 24;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps at MOD-1; wrap flags the terminal count while enabled.
module bcd_mod_counter #(
    parameter int unsigned MOD = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] q_lo,
    output logic [3:0] q_hi,
    output logic       wrap
);

    localparam logic [3:0] HI_MAX = 4'((MOD - 1) / 10);
    localparam logic [3:0] LO_MAX = 4'((MOD - 1) % 10);

    // Terminal count seen while counting: carry into the next field
    assign wrap = en && (q_hi == HI_MAX) && (q_lo == LO_MAX);

    // Digit registers; clear beats enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_lo <= 4'd0;
            q_hi <= 4'd0;
        end else if (clr) begin
            q_lo <= 4'd0;
            q_hi <= 4'd0;
        end else if (en) begin
            if (wrap) begin
                q_lo <= 4'd0;
                q_hi <= 4'd0;
            end else if (q_lo == 4'd9) begin
                q_lo <= 4'd0;
                q_hi <= q_hi + 4'd1;
            end else begin
                q_lo <= q_lo + 4'd1;
            end
        end
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// Run/stop/set controller: 1 Hz prescaler, BCD field chaining and the sec_tick strobe.
module clock_time_ctrl
    import clock_time_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic [3:0] hr_lo,
    output logic [3:0] hr_hi,
    output logic [1:0] state,
    output logic       sec_tick
);

    localparam int unsigned    PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    state_t           state_q;
    state_t           state_nx;
    logic [PRE_W-1:0] pre_q;
    logic             stay_run;
    logic             tick_int;
    logic             tick_go;
    logic             enter_set;
    logic             inc_ok;
    logic             sec_wrap;
    logic             min_wrap;
    logic             hr_wrap_unused;
    logic             min_en;
    logic             hr_en;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= STOP;
        else        state_q <= state_nx;
    end

    // Next state: mode beats run; run ignored while setting
    always_comb begin
        state_nx = state_q;
        case (state_q)
            STOP:    if (btn_mode) state_nx = SET_MIN; else if (btn_run) state_nx = RUN;
            RUN:     if (btn_mode) state_nx = SET_MIN; else if (btn_run) state_nx = STOP;
            SET_MIN: if (btn_mode) state_nx = SET_HR;
            SET_HR:  if (btn_mode) state_nx = STOP;
            default: state_nx = STOP;
        endcase
    end

    // Only an edge that stays in RUN advances time; a stop on the tick cycle wins
    assign stay_run  = (state_q == RUN) && (state_nx == RUN);
    assign tick_int  = (state_q == RUN) && (pre_q == PRE_MAX);
    assign tick_go   = tick_int && stay_run;
    assign enter_set = (state_nx == SET_MIN) && (state_q != SET_MIN);
    assign inc_ok    = btn_inc && !btn_mode;

    // Prescaler: frozen outside RUN so a resume keeps its phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         pre_q <= '0;
        else if (enter_set) pre_q <= '0;
        else if (stay_run)  pre_q <= tick_int ? '0 : pre_q + PRE_W'(1);
    end

    // Carries only ripple while running; set-mode increments never carry
    assign min_en = sec_wrap || ((state_q == SET_MIN) && inc_ok);
    assign hr_en  = (min_wrap && (state_q == RUN)) || ((state_q == SET_HR) && inc_ok);

    bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
        .clk(clk), .reset(reset), .en(tick_go), .clr(enter_set),
        .q_lo(sec_lo), .q_hi(sec_hi), .wrap(sec_wrap)
    );

    bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
        .clk(clk), .reset(reset), .en(min_en), .clr(1'b0),
        .q_lo(min_lo), .q_hi(min_hi), .wrap(min_wrap)
    );

    bcd_mod_counter #(.MOD(HR_MOD)) u_hr (
        .clk(clk), .reset(reset), .en(hr_en), .clr(1'b0),
        .q_lo(hr_lo), .q_hi(hr_hi), .wrap(hr_wrap_unused)
    );

    // Strobe aligned with the first cycle showing the new seconds
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sec_tick <= 1'b0;
        else        sec_tick <= tick_go;
    end

    assign state = state_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl with CLK_DIV=4, using a seconds-of-day model.
module tb_clock_time_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_run = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
    logic [1:0] state;
    logic       sec_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: time as seconds of day, state as 0..3, prescaler phase as integer
    int m_t     = 0;
    int m_state = 0;
    int m_pre   = 0;
    bit m_tick  = 0;

    wire [23:0] dut_digits = {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo};

    clock_time_ctrl #(.CLK_DIV(DIV)) dut (
        .clk(clk), .reset(reset),
        .btn_run(btn_run), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
        .hr_lo(hr_lo), .hr_hi(hr_hi), .state(state), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    function automatic [23:0] exp_digits();
        int h, mi, s;
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        s  = m_t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Behavioural reference for one clock edge
    task automatic model_step(input bit r, input bit m, input bit i);
        int  ns;
        bit  tick;
        tick = (m_state == 1) && (m_pre == DIV - 1);
        case (m_state)
            0:       ns = m ? 2 : (r ? 1 : 0);
            1:       ns = m ? 2 : (r ? 0 : 1);
            2:       ns = m ? 3 : 2;
            default: ns = m ? 0 : 3;
        endcase
        m_tick = 0;
        if (m_state == 1 && ns == 1) begin
            if (tick) begin
                m_t    = (m_t + 1) % 86400;
                m_tick = 1;
                m_pre  = 0;
            end else begin
                m_pre = m_pre + 1;
            end
        end
        if (ns == 2 && m_state != 2) begin
            m_t   = m_t - (m_t % 60);
            m_pre = 0;
        end
        if (m_state == 2 && !m && i)
            m_t = (m_t / 3600) * 3600 + ((((m_t / 60) % 60) + 1) % 60) * 60 + m_t % 60;
        if (m_state == 3 && !m && i)
            m_t = (((m_t / 3600) + 1) % 24) * 3600 + m_t % 3600;
        m_state = ns;
    endtask

    // One clock with the given pulses; returns 1 ns after the edge
    task automatic step(input bit r, input bit m, input bit i);
        btn_run  = r;
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        model_step(r, m, i);
        #1;
        btn_run  = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        m_t = 0; m_state = 0; m_pre = 0; m_tick = 0;
        #2;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (dut_digits !== 24'h000000) begin
            n_fail++; $display("FAIL reset_digits got %h want 000000", dut_digits);
        end
        n_checks++;
        if (state !== 2'd0 || sec_tick !== 1'b0) begin
            n_fail++; $display("FAIL reset_state got state=%0d tick=%b want 0/0", state, sec_tick);
        end
    endtask

    task automatic test_first_tick();
        step(1, 0, 0);
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++; $display("FAIL run_state got %0d want 1", state);
        end
        for (int k = 1; k <= 2 * DIV; k++) begin
            step(0, 0, 0);
            n_checks++;
            if (sec_tick !== ((k % DIV) == 0)) begin
                n_fail++; $display("FAIL first_tick_phase cycle %0d got %b want %b", k, sec_tick, (k % DIV) == 0);
            end
            if (k == DIV) begin
                n_checks++;
                if (dut_digits !== 24'h000001) begin
                    n_fail++; $display("FAIL first_tick_digits got %h want 000001", dut_digits);
                end
            end
        end
        n_checks++;
        if (dut_digits !== 24'h000002) begin
            n_fail++; $display("FAIL second_tick_digits got %h want 000002", dut_digits);
        end
    endtask

    task automatic test_minute();
        int ticks;
        int max_hi;
        apply_reset();
        step(1, 0, 0);
        ticks = 0;
        max_hi = 0;
        for (int k = 0; k < 60 * DIV; k++) begin
            step(0, 0, 0);
            if (sec_tick === 1'b1) ticks++;
            if (int'(sec_hi) > max_hi) max_hi = int'(sec_hi);
        end
        n_checks++;
        if (ticks != 60) begin
            n_fail++; $display("FAIL minute_tick_count got %0d want 60", ticks);
        end
        n_checks++;
        if (max_hi > 5) begin
            n_fail++; $display("FAIL minute_sec_hi_range got %0d want <=5", max_hi);
        end
        n_checks++;
        if (dut_digits !== 24'h000100 || dut_digits !== exp_digits()) begin
            n_fail++; $display("FAIL minute_digits got %h want 000100", dut_digits);
        end
    endtask

    task automatic test_set_modes();
        apply_reset();
        step(1, 0, 0);
        idle(3 * DIV);
        step(0, 1, 0);
        n_checks++;
        if (state !== 2'd2 || dut_digits !== 24'h000000) begin
            n_fail++; $display("FAIL set_min_entry got state=%0d digits=%h want 2/000000", state, dut_digits);
        end
        for (int k = 0; k < 3; k++) step(0, 0, 1);
        n_checks++;
        if (dut_digits !== 24'h000300) begin
            n_fail++; $display("FAIL set_min_inc got %h want 000300", dut_digits);
        end
        step(0, 1, 1);
        n_checks++;
        if (state !== 2'd3 || dut_digits !== 24'h000300) begin
            n_fail++; $display("FAIL mode_drops_inc got state=%0d digits=%h want 3/000300", state, dut_digits);
        end
        for (int k = 0; k < 25; k++) step(0, 0, 1);
        n_checks++;
        if (dut_digits !== 24'h010300) begin
            n_fail++; $display("FAIL set_hr_wrap got %h want 010300", dut_digits);
        end
        step(0, 1, 0);
        step(0, 0, 1);
        n_checks++;
        if (state !== 2'd0 || dut_digits !== 24'h010300) begin
            n_fail++; $display("FAIL set_exit_stop got state=%0d digits=%h want 0/010300", state, dut_digits);
        end
    endtask

    task automatic test_rollover();
        apply_reset();
        step(0, 1, 0);
        for (int k = 0; k < 59; k++) step(0, 0, 1);
        step(0, 1, 0);
        for (int k = 0; k < 23; k++) step(0, 0, 1);
        n_checks++;
        if (dut_digits !== 24'h235900) begin
            n_fail++; $display("FAIL preset got %h want 235900", dut_digits);
        end
        step(0, 1, 0);
        step(1, 0, 0);
        idle(59 * DIV);
        n_checks++;
        if (dut_digits !== 24'h235959) begin
            n_fail++; $display("FAIL pre_rollover got %h want 235959", dut_digits);
        end
        idle(DIV);
        n_checks++;
        if (dut_digits !== 24'h000000 || sec_tick !== 1'b1) begin
            n_fail++; $display("FAIL midnight got %h tick=%b want 000000 tick=1", dut_digits, sec_tick);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        step(1, 0, 0);
        idle(DIV + 1);
        step(1, 1, 0);
        n_checks++;
        if (state !== 2'd2) begin
            n_fail++; $display("FAIL mode_beats_run got %0d want 2", state);
        end
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        idle(DIV - 1);
        step(1, 0, 0);
        n_checks++;
        if (state !== 2'd0 || sec_tick !== 1'b0 || dut_digits !== 24'h000000) begin
            n_fail++; $display("FAIL stop_on_tick got state=%0d tick=%b digits=%h want 0/0/000000", state, sec_tick, dut_digits);
        end
        step(1, 0, 0);
        step(0, 0, 0);
        n_checks++;
        if (sec_tick !== 1'b1 || dut_digits !== 24'h000001) begin
            n_fail++; $display("FAIL resume_phase got tick=%b digits=%h want 1/000001", sec_tick, dut_digits);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int k = 0; k < 1500; k++) begin
            step(($urandom % 10) == 0, ($urandom % 24) == 0, ($urandom % 3) == 0);
            n_checks++;
            if (dut_digits !== exp_digits() || state !== 2'(m_state) || sec_tick !== m_tick) begin
                n_fail++;
                if (errs < 10)
                    $display("FAIL random cycle %0d got %h/%0d/%b want %h/%0d/%b", k, dut_digits, state,
                             sec_tick, exp_digits(), m_state, m_tick);
                errs++;
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(0, 1, 0);
        for (int k = 0; k < 34; k++) step(0, 0, 1);
        step(0, 1, 0);
        for (int k = 0; k < 12; k++) step(0, 0, 1);
        step(0, 1, 0);
        step(1, 0, 0);
        idle(56 * DIV);
        n_checks++;
        if (dut_digits !== 24'h123456 || state !== 2'd1) begin
            n_fail++; $display("FAIL preset_123456 got %h state=%0d want 123456/1", dut_digits, state);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (dut_digits !== 24'h000000 || state !== 2'd0 || sec_tick !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got %h state=%0d tick=%b want 000000/0/0", dut_digits, state, sec_tick);
        end
        m_t = 0; m_state = 0; m_pre = 0; m_tick = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_minute();
        test_set_modes();
        test_rollover();
        test_back_to_back();
        apply_reset();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
